iob_mem_burst_ctrl: RTL and testbench
=====================================

Name: iob_mem_burst_ctrl

Overview:
- Burst initiator that drives a single-address tiled 2-port memory: memory-side outputs are w_en/r_en/addr/data_in; data_out is returned from the memory.
- Accepts one burst command at a time (start address, length, direction) over a valid/ready handshake.
- Write bursts take data from a valid/ready write stream; read bursts return data on a valid/ready read stream with full backpressure.
- Sits between a CPU/DMA-side stream fabric and the tiled memory.

Parameters:
- DATA_W, 32, data word width; must match the memory.
- ADDR_W, 13, memory word-address width.
- LEN_W, 8, burst length field width; a burst is req_len+1 words.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  burst command valid
- req_ready  out  1  controller idle, command accepted when valid&ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start word address
- req_len  in  LEN_W  word count minus one
- wr_valid  in  1  write data valid
- wr_ready  out  1  write data accepted when valid&ready
- wr_data  in  DATA_W  write data
- rd_valid  out  1  read data valid
- rd_ready  in  1  read data consumer ready
- rd_data  out  DATA_W  read data
- done  out  1  one-cycle pulse on the cycle the last word completes
- mem_w_en  out  1  memory write enable
- mem_r_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W  memory read data, registered, valid one cycle after mem_r_en while mem_addr is held

Behaviour:
- Reset:
  - State is IDLE.
  - req_ready=1.
  - wr_ready, rd_valid, done, mem_w_en and mem_r_en are all 0.
  - mem_addr, mem_data_in and rd_data are 0.
  - The address and remaining-count registers are 0.
- State machine: IDLE, WRITE, RD_ISSUE, RD_CAPT, RD_HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr into the address register and req_len into the count register.
  - Go to WRITE if req_write=1, otherwise RD_ISSUE.
  - req_ready is 0 in every other state.
- WRITE:
  - wr_ready=1.
  - mem_w_en is driven combinationally as wr_valid; mem_data_in=wr_data; mem_addr=address register.
  - On each wr_valid: increment the address register and decrement the count register.
  - When the count is 0 at the accepting cycle: assert done next cycle and return to IDLE.
  - Throughput is 1 word/cycle, stalling on wr_valid=0.
- RD_ISSUE: mem_r_en=1 for one cycle, then go to RD_CAPT.
- RD_CAPT:
  - mem_addr is held unchanged. This is required because the memory output mux selects by the current address.
  - Capture mem_data_out into rd_data and set rd_valid=1, then go to RD_HOLD.
- RD_HOLD:
  - Hold rd_valid/rd_data until rd_ready.
  - On the handshake:
    - If count is 0: clear rd_valid, pulse done, go to IDLE.
    - Otherwise: increment the address, decrement the count, clear rd_valid, go to RD_ISSUE.
  - Read throughput is 1 word per 3 cycles with rd_ready held high; this is the accepted rate.
- Address arithmetic: modulo 2^ADDR_W. A burst crossing the top address wraps to 0 with no error; crossing a tile boundary needs no special handling.
- mem_r_en and mem_w_en are never both 1.
- mem_w_en is never asserted outside WRITE; mem_r_en is never asserted outside RD_ISSUE.
- The memory-side outputs other than mem_w_en/mem_data_in are registered.
- A new command cannot be accepted on the same cycle that done pulses; the earliest acceptance is the cycle after.
- req_valid while busy is ignored (no overwrite); the command is held by the requester per the handshake.
- rst mid-burst: abort immediately to the reset state. Remaining words are dropped, no done pulse, rd_valid drops.
- req_len=0 gives a single-word burst.

Decomposition:
- A shared package holds the state encoding constants (IDLE..RD_HOLD, 3-bit).
- No sub-module: the address/count datapath and FSM fit in one module.
- The existing iob_2p_mem_tiled serves only as the memory model in the testbench.

Test Plan:
- Reset then single write: req addr=0x005, len=0, wr_data=0xDEADBEEF -> mem_w_en for 1 cycle at addr 0x005, done pulses next cycle, req_ready=1.
- Write burst of 4 from 0x7FE with gaps in wr_valid -> writes at 0x7FE, 0x7FF, 0x800, 0x801 (tile crossing); memory contents match; mem_w_en only on wr_valid cycles.
- Read back the same 4 words with rd_ready=1 -> rd_data sequence matches; each word takes 3 cycles; done after the fourth handshake.
- Read burst with rd_ready held 0 for 5 cycles on word 2 -> rd_data stable, no new mem_r_en, no data loss.
- Write burst len=2 from 0x1FFF (ADDR_W=13) -> addresses 0x1FFF, 0x0000, 0x0001.
- Assert rst during a read burst at word 1 -> all outputs return to reset values within the same cycle, no done pulse; a subsequent command is accepted normally.

Source files
------------

// File: rtl/iob_mem_burst_ctrl_pkg.sv
// Shared definitions for the memory burst controller.
// Holds the 3-bit FSM state encoding used by the controller.
// No logic; imported by the controller.
package iob_mem_burst_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RD_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/iob_mem_burst_ctrl.sv
// Burst initiator for a single-address tiled memory: one command at a time, write and read streams.
// Latency: writes go to memory the cycle they are accepted (1 word/cycle); reads deliver 1 word per 3 cycles.
// Backpressure: write stream stalls on wr_valid=0; read data is held until rd_ready, no new read issued meanwhile.
module iob_mem_burst_ctrl
  import iob_mem_burst_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              mem_w_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              r_en_q, r_en_d;
  logic              last_word;

  // Remaining count of zero means the word in flight is the last of the burst.
  assign last_word = (cnt_q == '0);

  // State and datapath registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      r_en_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      r_en_q     <= r_en_d;
    end
  end

  // Next-state logic, address/count stepping and read capture.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // done_q blocks acceptance so a new command never lands on the done cycle.
        if (req_valid && !done_q) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          state_d = req_write ? ST_WRITE : ST_RD_ISSUE;
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          if (last_word) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - LEN_W'(1);
          end
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_CAPT;
      end
      ST_RD_CAPT: begin
        // Address is still held here, so the tile output mux returns the right word.
        rd_data_d  = mem_data_out;
        rd_valid_d = 1'b1;
        state_d    = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (last_word) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = ST_RD_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Registered read enable is high exactly while the FSM sits in RD_ISSUE.
    r_en_d = (state_d == ST_RD_ISSUE);
  end

  assign req_ready   = (state_q == ST_IDLE) && !done_q;
  assign wr_ready    = (state_q == ST_WRITE);
  assign mem_w_en    = wr_ready && wr_valid;
  assign mem_data_in = wr_ready ? wr_data : '0;
  assign mem_r_en    = r_en_q;
  assign mem_addr    = addr_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q;

endmodule

// File: tb/tb_iob_mem_burst_ctrl.sv
// Bench for iob_mem_burst_ctrl with a behavioural memory and a scoreboard of expected traffic.
// Latency: n/a.
// Backpressure: exercises write gaps and read stalls.
module tb_iob_mem_burst_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              mem_w_en;
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  always #5 clk = ~clk;

  iob_mem_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Memory model: synchronous write, registered read output.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_data_in;
    if (mem_r_en) mem_data_out <= mem[mem_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                last;
  } exp_t;

  exp_t              wq[$];
  exp_t              rq[$];
  logic [ADDR_W-1:0] raq[$];
  logic [DATA_W-1:0] ref_mem [int];
  int                hs_times[$];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                rd_hs_cnt = 0;
  bit                done_pend = 1'b0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_rd_data = '0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic void chk_empty_pop(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_event required=no_event", nm);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT shows memory or read-stream activity.
  always @(negedge clk) begin
    exp_t e;
    logic [ADDR_W-1:0] ea;
    if (rst) begin
      done_pend  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_timing", done, done_pend);
      done_pend = 1'b0;
      if (done) chk("req_ready_on_done", req_ready, 0);
      if (mem_w_en || mem_r_en) chk("exclusive_en", mem_w_en & mem_r_en, 0);
      if (wr_ready || mem_w_en) chk("w_en_is_handshake", mem_w_en, wr_valid & wr_ready);
      if (mem_w_en) begin
        if (wq.size() == 0) chk_empty_pop("unexpected_write");
        else begin
          e = wq.pop_front();
          chk("write_addr", mem_addr, e.addr);
          chk("write_data", mem_data_in, e.data);
          if (e.last) done_pend = 1'b1;
        end
      end
      if (mem_r_en) begin
        chk("r_en_while_holding", rd_valid, 0);
        if (raq.size() == 0) chk_empty_pop("unexpected_read");
        else begin
          ea = raq.pop_front();
          chk("read_addr", mem_addr, ea);
        end
      end
      if (prev_stall) begin
        chk("stall_valid_held", rd_valid, 1);
        chk("stall_data_held", rd_data, prev_rd_data);
      end
      if (rd_valid && rd_ready) begin
        rd_hs_cnt++;
        hs_times.push_back(cyc);
        if (rq.size() == 0) chk_empty_pop("unexpected_rd_word");
        else begin
          e = rq.pop_front();
          chk("rd_data", rd_data, e.data);
          if (e.last) done_pend = 1'b1;
        end
      end
      prev_stall   = rd_valid && !rd_ready;
      prev_rd_data = rd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input bit w, input int a, input int l);
    int n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a[ADDR_W-1:0];
    req_len   = l[LEN_W-1:0];
    while (!req_ready && n < 100) begin tick(); n++; end
    chk("req_accept_in_time", n < 100, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!done && n < 400) begin
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("done_in_time", n < 400, 1);
    rd_ready = 1'b1;
    tick();
    chk("req_ready_after_done", req_ready, 1);
  endtask

  task automatic write_burst(input int a, input int l, input bit gaps,
                             input bit fixed, input logic [DATA_W-1:0] fv);
    logic [DATA_W-1:0] d[$];
    logic [DATA_W-1:0] dv;
    logic [ADDR_W-1:0] ad;
    int n;
    for (int i = 0; i <= l; i++) begin
      dv = fixed ? fv + DATA_W'(i) : $urandom;
      ad = ADDR_W'((a + i) % DEPTH);
      d.push_back(dv);
      wq.push_back('{ad, dv, i == l});
      ref_mem[int'(ad)] = dv;
    end
    issue_cmd(1'b1, a, l);
    for (int i = 0; i < d.size(); i++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      wr_valid = 1'b1;
      wr_data  = d[i];
      n = 0;
      while (!wr_ready && n < 100) begin tick(); n++; end
      tick();
    end
    wr_valid = 1'b0;
    wait_done(1'b0);
    chk("write_queue_drained", wq.size(), 0);
  endtask

  task automatic read_burst(input int a, input int l);
    logic [ADDR_W-1:0] ad;
    for (int i = 0; i <= l; i++) begin
      ad = ADDR_W'((a + i) % DEPTH);
      raq.push_back(ad);
      rq.push_back('{ad, ref_mem[int'(ad)], i == l});
    end
    issue_cmd(1'b0, a, l);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (rd_hs_cnt < target && n < 100) begin tick(); n++; end
    chk("rd_handshake_in_time", n < 100, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int base;
    int a;
    int l;
    int off;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_w_en", mem_w_en, 0);
    chk("rst_r_en", mem_r_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Single-word write.
    write_burst('h005, 0, 1'b0, 1'b1, 32'hDEADBEEF);
    // Four words across a tile boundary with gaps on the write stream.
    write_burst('h7FE, 3, 1'b1, 1'b0, '0);

    // Read back at full rate; words spaced three cycles apart.
    rd_ready = 1'b1;
    hs_times.delete();
    read_burst('h7FE, 3);
    wait_done(1'b0);
    chk("rd_hs_count", hs_times.size(), 4);
    for (int i = 1; i < 4 && i < hs_times.size(); i++)
      chk("rd_word_spacing", hs_times[i] - hs_times[i-1], 3);
    chk("read_queue_drained", rq.size() + raq.size(), 0);

    // Stall the third word for five cycles.
    rd_ready = 1'b1;
    base = rd_hs_cnt;
    read_burst('h7FE, 3);
    wait_hs(base + 2);
    rd_ready = 1'b0;
    for (int n = 0; n < 50 && !rd_valid; n++) tick();
    repeat (5) tick();
    rd_ready = 1'b1;
    wait_done(1'b0);
    chk("stall_read_drained", rq.size() + raq.size(), 0);

    // Wrap past the top of the address space.
    write_burst('h1FFF, 2, 1'b1, 1'b0, '0);
    read_burst('h1FFF, 2);
    wait_done(1'b0);

    // Reset in the middle of a read burst.
    rd_ready = 1'b1;
    base = rd_hs_cnt;
    read_burst('h7FE, 3);
    wait_hs(base + 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_req_ready", req_ready, 1);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_r_en", mem_r_en, 0);
    chk("abort_w_en", mem_w_en, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_rd_data", rd_data, 0);
    wq.delete();
    rq.delete();
    raq.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_abort_no_done", done, 0);
    chk("post_abort_idle", req_ready, 1);
    write_burst('h0100, 1, 1'b0, 1'b0, '0);
    read_burst('h0100, 1);
    wait_done(1'b0);

    // Random bursts, each read back over a random sub-range with random backpressure.
    for (int it = 0; it < 8; it++) begin
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 7);
      write_burst(a, l, 1'b1, 1'b0, '0);
      off = $urandom_range(0, l);
      read_burst((a + off) % DEPTH, $urandom_range(0, l - off));
      wait_done(1'b1);
      chk("rand_read_drained", rq.size() + raq.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
